// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_e        : responder FSM states
//   SzByte/Half/Word: access size codes (2'b11 is treated as a word)
//   lane_mask      : byte enables for a store of a given size and byte offset
//   misaligned     : alignment fault for a given size and byte offset
//   extend_load    : sign/zero extension of a byte or halfword load value
package dmem_responder_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  function automatic logic [3:0] lane_mask(logic [1:0] size, logic [1:0] off);
    logic [3:0] mask;
    case (size)
      SzByte:  mask = 4'b0001 << off;
      SzHalf:  mask = 4'b0011 << {off[1], 1'b0};
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
    logic mis;
    case (size)
      SzByte:  mis = 1'b0;
      SzHalf:  mis = off[0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  // val holds the loaded byte in [7:0] or halfword in [15:0], right-aligned.
  function automatic logic [31:0] extend_load(logic [15:0] val, logic is_half, logic uns);
    logic [31:0] res;
    if (is_half) begin
      res = uns ? {16'h0000, val} : {{16{val[15]}}, val};
    end else begin
      res = uns ? {24'h000000, val[7:0]} : {{24{val[7]}}, val[7:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic for one memory word.
//   size_i, off_i : access size code and byte offset within the word
//   uns_i         : zero-extend (1) or sign-extend (0) narrow loads
//   wdata_i       : right-aligned store data
//   rword_i       : current contents of the addressed word
//   be_o          : byte enables of the store
//   mis_o         : access is misaligned
//   merged_o      : word to write back (store lanes merged over rword_i)
//   rdata_o       : extracted and extended load value
module dmem_lane
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic        mis_o,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [31:0] wrep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o     = lane_mask(size_i, off_i);
    mis_o    = misaligned(size_i, off_i);
    wrep     = wdata_i;
    merged_o = rword_i;
    rdata_o  = rword_i;

    // Replicate the store data across all lanes; the enables pick the live ones.
    case (size_i)
      SzByte:  wrep = {4{wdata_i[7:0]}};
      SzHalf:  wrep = {2{wdata_i[15:0]}};
      default: wrep = wdata_i;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_o[8*i +: 8] = be_o[i] ? wrep[8*i +: 8] : rword_i[8*i +: 8];
    end

    byte_sel = rword_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SzByte:  rdata_o = extend_load({8'h00, byte_sel}, 1'b0, uns_i);
      SzHalf:  rdata_o = extend_load(half_sel, 1'b1, uns_i);
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: services one load/store at a time with a fixed latency.
//   clk, reset       : clock and synchronous active-high reset
//   memread/memwrite : load / store request (both high is a store)
//   size, ldunsigned : access size code and load zero-extension select
//   addr, writedata  : byte address and right-aligned store data
//   readdata         : load result, valid while ready=1
//   ready            : one-cycle completion pulse
//   misalign         : qualifies ready; the access was not performed
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW      = 6,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        ldunsigned,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        misalign
);

  localparam int unsigned Depth    = 2 ** AW;
  localparam bit          OneCycle = (LATENCY == 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          wr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   readdata_q;
  logic          ready_q;
  logic          misalign_q;
  logic [31:0]   mem_q [Depth];

  logic          in_idle, req, commit;
  logic [AW+1:0] acc_addr;
  logic [1:0]    acc_size;
  logic          acc_uns, acc_wr;
  logic [31:0]   acc_wdata, rword, result;
  logic [3:0]    lane_be;
  logic          lane_mis;
  logic [31:0]   lane_merged, lane_rdata;
  logic          unused_addr;

  assign unused_addr = ^addr[31:AW+2];

  assign in_idle = (state_q == StIdle);
  assign req     = memread | memwrite;

  // With a one-cycle latency the access completes on its acceptance edge, before
  // anything is latched, so the live inputs feed the lane logic while idle.
  assign acc_addr  = in_idle ? addr[AW+1:0] : addr_q;
  assign acc_size  = in_idle ? size         : size_q;
  assign acc_uns   = in_idle ? ldunsigned   : uns_q;
  assign acc_wr    = in_idle ? memwrite     : wr_q;
  assign acc_wdata = in_idle ? writedata    : wdata_q;

  assign commit = (in_idle && req && OneCycle) || (state_q == StBusy && cnt_q == 4'd1);
  assign rword  = mem_q[acc_addr[AW+1:2]];
  assign result = (acc_wr || lane_mis) ? 32'h0 : lane_rdata;

  dmem_lane u_lane (
    .size_i   (acc_size),
    .off_i    (acc_addr[1:0]),
    .uns_i    (acc_uns),
    .wdata_i  (acc_wdata),
    .rword_i  (rword),
    .be_o     (lane_be),
    .mis_o    (lane_mis),
    .merged_o (lane_merged),
    .rdata_o  (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
      readdata_q <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          ready_q    <= 1'b0;
          misalign_q <= 1'b0;
          readdata_q <= 32'h0;
          if (req) begin
            addr_q  <= addr[AW+1:0];
            size_q  <= size;
            uns_q   <= ldunsigned;
            wr_q    <= memwrite;
            wdata_q <= writedata;
            if (OneCycle) begin
              state_q    <= StDone;
              ready_q    <= 1'b1;
              misalign_q <= lane_mis;
              readdata_q <= result;
            end else begin
              state_q <= StBusy;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= StDone;
            ready_q    <= 1'b1;
            misalign_q <= lane_mis;
            readdata_q <= result;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          ready_q    <= 1'b0;
          misalign_q <= 1'b0;
          readdata_q <= 32'h0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage is never cleared; a reset on the commit edge still blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && acc_wr && !lane_mis && (|lane_be)) begin
      mem_q[acc_addr[AW+1:2]] <= lane_merged;
    end
  end

  assign readdata = readdata_q;
  assign ready    = ready_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        memread, memwrite, ldunsigned;
  logic [1:0]  size;
  logic [31:0] addr, writedata;
  logic        rst [3];
  logic [31:0] rd  [3];
  logic        rdy [3];
  logic        mis [3];

  int n_vec = 0;
  int n_err = 0;

  // Byte-level reference memory, one per DUT (DUT 2 may diverge after resets).
  logic [7:0] mb [3][256];

  always #5 clk = ~clk;

  dmem_responder #(.AW(6), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst[0]), .memread(memread), .memwrite(memwrite), .size(size),
    .ldunsigned(ldunsigned), .addr(addr), .writedata(writedata), .readdata(rd[0]),
    .ready(rdy[0]), .misalign(mis[0])
  );
  dmem_responder #(.AW(6), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .memread(memread), .memwrite(memwrite), .size(size),
    .ldunsigned(ldunsigned), .addr(addr), .writedata(writedata), .readdata(rd[1]),
    .ready(rdy[1]), .misalign(mis[1])
  );
  dmem_responder #(.AW(6), .LATENCY(4)) u_dut2 (
    .clk(clk), .reset(rst[2]), .memread(memread), .memwrite(memwrite), .size(size),
    .ldunsigned(ldunsigned), .addr(addr), .writedata(writedata), .readdata(rd[2]),
    .ready(rdy[2]), .misalign(mis[2])
  );

  function automatic int lat(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access, request held for a single cycle. rst_k>0 pulses DUT 2's reset
  // from the k-th negedge after acceptance, so it covers the k-th edge.
  task automatic access(input logic rd_i, input logic wr_i, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input int rst_k, output logic [31:0] rd0);
    int          n, base;
    logic        mis_e;
    logic [31:0] exp_rd [3];
    int          seen [3];
    int          np [3];
    logic [31:0] got_rd [3];
    logic        got_mis [3];
    n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis_e = (a % n) != 0;
    base  = int'(a % 256);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      v = 32'h0;
      for (int j = 0; j < n; j++) v = v | (32'(mb[i][(base + j) % 256]) << (8 * j));
      if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd[i] = (wr_i || mis_e) ? 32'h0 : v;
      seen[i] = 0; np[i] = 0; got_rd[i] = 32'h0; got_mis[i] = 1'b0;
    end
    @(negedge clk);
    memread = rd_i; memwrite = wr_i; size = sz; ldunsigned = uns; addr = a; writedata = wd;
    @(posedge clk);
    #1;
    memread = 1'b0; memwrite = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rdy[i] === 1'b1) begin
          np[i]++;
          if (seen[i] == 0) begin
            seen[i] = k; got_rd[i] = rd[i]; got_mis[i] = mis[i];
          end
        end
      end
      if (rst_k != 0 && k == rst_k) rst[2] = 1'b1;
      if (rst_k != 0 && k == rst_k + 1) rst[2] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2 && rst_k != 0) begin
        chk($sformatf("rst_pulses%0d", i), np[i], 0);
      end else begin
        chk($sformatf("pulses%0d@%h", i, a), np[i], 1);
        chk($sformatf("latency%0d@%h", i, a), seen[i], lat(i));
        chk($sformatf("rdata%0d@%h", i, a), got_rd[i], exp_rd[i]);
        chk($sformatf("misalign%0d@%h", i, a), 32'(got_mis[i]), 32'(mis_e));
        if (wr_i && !mis_e)
          for (int j = 0; j < n; j++) mb[i][(base + j) % 256] = wd[8*j +: 8];
      end
    end
    rd0 = got_rd[0];
  endtask

  initial begin
    logic [31:0] r;
    int          pt [3][8];
    int          npl [3];
    memread = 0; memwrite = 0; size = 0; ldunsigned = 0; addr = 0; writedata = 0;
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready%0d", i), 32'(rdy[i]), 32'h0);
      chk($sformatf("reset_misalign%0d", i), 32'(mis[i]), 32'h0);
      chk($sformatf("reset_readdata%0d", i), rd[i], 32'h0);
      rst[i] = 1'b0;
    end

    // Storage is not reset: zero it through the normal store path.
    for (int w = 0; w < 64; w++) access(1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), 32'h0, 0, r);

    access(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, r);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, r);          chk("lw_10", r, 32'hDEAD_BEEF);

    access(0, 1, 2'b10, 0, 32'h20, 32'h1122_3344, 0, r);
    access(0, 1, 2'b00, 0, 32'h22, 32'h0000_00AA, 0, r);
    access(1, 0, 2'b10, 0, 32'h20, 32'h0, 0, r);          chk("lw_20", r, 32'h11AA_3344);
    access(1, 0, 2'b00, 0, 32'h22, 32'h0, 0, r);          chk("lb_22", r, 32'hFFFF_FFAA);
    access(1, 0, 2'b00, 1, 32'h22, 32'h0, 0, r);          chk("lbu_22", r, 32'h0000_00AA);

    access(0, 1, 2'b01, 0, 32'h32, 32'h0000_8001, 0, r);
    access(1, 0, 2'b01, 0, 32'h32, 32'h0, 0, r);          chk("lh_32", r, 32'hFFFF_8001);
    access(1, 0, 2'b01, 1, 32'h32, 32'h0, 0, r);          chk("lhu_32", r, 32'h0000_8001);
    access(0, 1, 2'b01, 0, 32'h31, 32'h0000_FFFF, 0, r);  chk("sh_31_rdata", r, 32'h0);
    access(1, 0, 2'b10, 0, 32'h30, 32'h0, 0, r);          chk("lw_30", r, 32'h8001_0000);

    access(0, 1, 2'b10, 0, 32'h100, 32'h5, 0, r);
    access(1, 0, 2'b10, 0, 32'h000, 32'h0, 0, r);         chk("wrap_lw_0", r, 32'h5);

    // DUT 2 (latency 4): reset one cycle after acceptance, then on the commit edge.
    access(0, 1, 2'b10, 0, 32'h40, 32'h77, 1, r);
    access(1, 0, 2'b10, 0, 32'h40, 32'h0, 0, r);
    chk("rst_mid_lw_40", u_dut2.readdata_q === 32'h0 ? 32'h0 : 32'h1, 32'h0);
    access(0, 1, 2'b10, 0, 32'h44, 32'h99, 3, r);
    access(1, 0, 2'b10, 0, 32'h44, 32'h0, 0, r);

    access(1, 1, 2'b10, 0, 32'h50, 32'h1234_5678, 0, r);  chk("rdwr_rdata", r, 32'h0);
    access(1, 0, 2'b10, 0, 32'h50, 32'h0, 0, r);          chk("rdwr_lw_50", r, 32'h1234_5678);

    for (int t = 0; t < 150; t++) begin
      int op;
      op = int'($urandom_range(0, 3));
      access((op != 1), (op == 1 || op == 2), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range(0, 511)), $urandom, 0, r);
    end

    // Request held high: each DUT restarts one bubble cycle after its ready.
    for (int i = 0; i < 3; i++) begin
      npl[i] = 0;
      for (int p = 0; p < 8; p++) pt[i][p] = -100;
    end
    @(negedge clk);
    memread = 1; memwrite = 0; size = 2'b10; ldunsigned = 0; addr = 32'h10;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rdy[i] === 1'b1 && npl[i] < 8) begin
          pt[i][npl[i]] = k;
          npl[i]++;
        end
      end
    end
    memread = 0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("held_count%0d", i), 32'(npl[i] >= 3), 32'h1);
      chk($sformatf("held_first%0d", i), pt[i][0], lat(i));
      chk($sformatf("held_gap1_%0d", i), pt[i][1] - pt[i][0], lat(i) + 1);
      chk($sformatf("held_gap2_%0d", i), pt[i][2] - pt[i][1], lat(i) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the datapath's load/store interface. The datapath drives address, write data and strobes; this block returns readdata.
- Services one access at a time over a fixed, parameterised latency and raises ready for exactly one cycle on completion. The control path stalls the pipeline until ready.
- Supports word, halfword and byte loads and stores, little-endian, with misalignment detection.

Parameters:
- AW, 6, word-address width; storage is 2**AW 32-bit words.
- LATENCY, 2, cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- memread  input  1  load request.
- memwrite  input  1  store request.
- size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal (treated as word).
- ldunsigned  input  1  zero-extend byte/halfword loads when 1, sign-extend when 0.
- addr  input  32  byte address (the datapath's aluout).
- writedata  input  32  store data, right-aligned.
- readdata  output  32  load result; valid only while ready=1.
- ready  output  1  one-cycle completion pulse.
- misalign  output  1  qualifies ready; the access was misaligned and was not performed.

Behaviour:
- Reset: the clock is clk; reset is synchronous and active-high.
  - State returns to IDLE; ready=0, misalign=0, readdata=0, counter=0.
  - Storage contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if memread|memwrite, latch addr, size, ldunsigned, writedata and the op. Go to BUSY with count=LATENCY-1, or straight to DONE when LATENCY=1.
- BUSY: decrement count each cycle; on the count==1 edge go to DONE.
  - The array write commits on that transition edge; the read sample is taken on the same edge.
  - Inputs are ignored while in BUSY. The requester holds its request stable, but the block uses only latched values.
- DONE: ready=1 and misalign/readdata are valid for one cycle; next state is always IDLE.
  - A request still asserted in the following IDLE cycle is a new access, so there is a minimum one-cycle bubble between accesses.
- Latency: ready asserts exactly LATENCY cycles after the IDLE acceptance edge.
- Index and wrap: word index = addr[AW+1:2]; upper address bits are ignored, so addresses wrap modulo 4*2**AW bytes.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - A misaligned access performs no write, returns readdata=0 and raises misalign=1 with ready. Latency is unchanged.
- Stores:
  - Byte: writedata[7:0] goes to lane addr[1:0].
  - Halfword: writedata[15:0] goes to lanes {addr[1],0}+1 : {addr[1],0}.
  - Other lanes are preserved (read-modify-write internal to the edge).
- Loads: select a lane by addr[1:0] or addr[1], then sign- or zero-extend to 32 bits per ldunsigned. A word load returns the whole word.
- memread and memwrite both high: treated as a store; readdata=0.
- Reset mid-operation: reset in BUSY before the commit edge discards the access and no write occurs. Reset on the commit edge itself also suppresses the write.
- Read-after-write: a load issued after a store's ready returns the new data.

Decomposition:
- Shared package holds:
  - State encodings IDLE/BUSY/DONE.
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - Lane-mask and extend helper functions.
- One sub-module, dmem_lane: combinational byte-enable and store-merge plus load extract and extend, reused by the FSM. Storage and FSM stay in dmem_responder.

Test Plan:
- Word store then load: sw 0xDEADBEEF to 0x10, then lw 0x10. ready pulses LATENCY cycles after each acceptance; readdata=0xDEADBEEF, misalign=0.
- Byte lanes: after sw 0x11223344 to 0x20, sb 0xAA to 0x22. lw 0x20 returns 0x11AA3344; lb 0x22 returns 0xFFFFFFAA; lbu 0x22 returns 0x000000AA.
- Halfword: sh 0x8001 to 0x32, then lh 0x32 returns 0xFFFF8001 and lhu 0x32 returns 0x00008001. sh to 0x31 gives misalign=1, readdata=0, and the memory word is unchanged.
- Wrap: with AW=6, sw 0x5 to 0x100, then lw 0x000 returns 0x5.
- Reset mid-op: with LATENCY=4, sw 0x77 to 0x40 after the prior word was 0x0, and reset asserted one cycle after acceptance. No ready pulse; a later lw 0x40 returns 0x0.
- Boundaries: LATENCY=1 gives ready on the cycle after acceptance. A request held high for 3 back-to-back accesses gives ready pulses separated by exactly LATENCY+1 cycles. memread=memwrite=1 performs the store and returns readdata=0.
